pipe_stage_chain: RTL and testbench

- Parametrised, multi-stage pipeline register chain that replaces the per-boundary fixed register blocks in the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds per-stage valid bits, valid/ready backpressure, global stall, synchronous flush and bubble collapse.
- Control bits of empty stages are forced to zero, so downstream never sees a spurious RegWrite/MemWrite.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_slot.sv | 57 +++++
 rtl/pipe_stage_chain.sv | 106 ++++++++++
 tb/tb_pipe_stage_chain.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions, default widths
// and the entry bundle carried between datapath stages.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_BITS  = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_BRANCH   = 4;

  typedef struct packed {
    logic [2*XLEN-1:0]     data;
    logic [CTRL_BITS-1:0]  ctrl;
    logic [REG_ADDR_W-1:0] tag;
  } pipe_entry_t;

  function automatic logic [3:0] popcnt8(
    input logic [7:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register stage: valid bit plus data/ctrl/tag.
// Ctrl is zero whenever the stage is empty.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int TAG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_load,
  input  logic              i_leave,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [TAG_W-1:0]  o_tag
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [TAG_W-1:0]  r_tag;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_tag   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_ctrl  <= i_valid ? i_ctrl : '0;
      if (i_valid) begin
        r_data <= i_data;
        r_tag  <= i_tag;
      end
    end else if (i_leave) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipe_stage_chain.sv
// Valid/ready pipeline register chain with stall, flush and
// bubble collapse; outputs come straight from the last stage.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 1,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [TAG_W-1:0]  out_tag_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CW-1:0]     count_o
);

  logic [DEPTH-1:0]             w_valid;
  logic [DEPTH-1:0][DATA_W-1:0] w_data;
  logic [DEPTH-1:0][CTRL_W-1:0] w_ctrl;
  logic [DEPTH-1:0][TAG_W-1:0]  w_tag;
  logic [DEPTH-1:0]             w_load;
  logic [DEPTH-1:0]             w_leave;
  logic                         w_lv;
  logic [7:0]                   w_vpad;
  logic [3:0]                   w_pop;

  // Ready ripples from the output back to stage 0.
  always_comb begin
    w_load  = '0;
    w_leave = '0;
    w_lv    = out_ready_i & ~stall_i;
    for (int k = DEPTH-1; k >= 0; k--) begin
      w_leave[k] = w_lv;
      w_load[k]  = ~stall_i & ~flush_i
                 & (~w_valid[k] | w_lv);
      w_lv       = w_load[k];
    end
  end

  assign in_ready_o = w_load[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              w_sv;
    logic [DATA_W-1:0] w_sd;
    logic [CTRL_W-1:0] w_sc;
    logic [TAG_W-1:0]  w_st;

    if (k == 0) begin : g_head
      assign w_sv = in_valid_i;
      assign w_sd = in_data_i;
      assign w_sc = in_ctrl_i;
      assign w_st = in_tag_i;
    end else begin : g_body
      assign w_sv = w_valid[k-1];
      assign w_sd = w_data[k-1];
      assign w_sc = w_ctrl[k-1];
      assign w_st = w_tag[k-1];
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .TAG_W  (TAG_W)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_load  (w_load[k]),
      .i_leave (w_leave[k]),
      .i_flush (flush_i),
      .i_valid (w_sv),
      .i_data  (w_sd),
      .i_ctrl  (w_sc),
      .i_tag   (w_st),
      .o_valid (w_valid[k]),
      .o_data  (w_data[k]),
      .o_ctrl  (w_ctrl[k]),
      .o_tag   (w_tag[k])
    );
  end

  always_comb begin
    w_vpad = '0;
    w_vpad[DEPTH-1:0] = w_valid;
  end

  assign w_pop   = popcnt8(w_vpad);
  assign count_o = w_pop[CW-1:0];

  assign out_valid_o = w_valid[DEPTH-1];
  assign out_data_o  = w_data[DEPTH-1];
  assign out_ctrl_o  = w_ctrl[DEPTH-1];
  assign out_tag_o   = w_tag[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain at DEPTH=3.
// Inputs change 1 time unit after the rising edge.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int CWD = 8;
  localparam int TW = 5;
  localparam int D = 3;
  localparam int NW = $clog2(D+1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic [CWD-1:0] in_ctrl_i;
  logic [TW-1:0] in_tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [CWD-1:0] out_ctrl_o;
  logic [TW-1:0] out_tag_o;
  logic          stall_i;
  logic          flush_i;
  logic [NW-1:0] count_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_chain #(
    .DATA_W (DW),
    .CTRL_W (CWD),
    .TAG_W  (TW),
    .DEPTH  (D)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_ctrl_i   (in_ctrl_i),
    .in_tag_i    (in_tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ctrl_o  (out_ctrl_o),
    .out_tag_o   (out_tag_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .count_o     (count_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [63:0] d,
                       input logic [7:0] c);
    in_valid_i = v;
    in_data_i  = d;
    in_ctrl_i  = c;
    in_tag_i   = d[4:0];
  endtask

  initial begin
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    stall_i     = 1'b0;
    flush_i     = 1'b0;
    drive(1'b1, 64'hDEAD, 8'hFF);

    // reset
    step();
    step();
    chk("rst_valid", {63'b0, out_valid_o}, 64'd0);
    chk("rst_ctrl", {56'b0, out_ctrl_o}, 64'd0);
    chk("rst_data", out_data_o, 64'd0);
    chk("rst_tag", {59'b0, out_tag_o}, 64'd0);
    chk("rst_count", {62'b0, count_o}, 64'd0);
    drive(1'b0, 64'd0, 8'h00);
    rst_i = 1'b1;
    #1;
    chk("rst_ready", {63'b0, in_ready_o}, 64'd1);

    // streaming 1..10, three-edge latency
    for (int c = 0; c < 13; c++) begin
      if (c < 10) drive(1'b1, 64'(c+1), 8'h01);
      else        drive(1'b0, 64'd0, 8'h00);
      #1;
      if (c < 10)
        chk("str_ready", {63'b0, in_ready_o}, 64'd1);
      step();
      if (c >= 2 && c <= 11) begin
        chk("str_valid", {63'b0, out_valid_o}, 64'd1);
        chk("str_data", out_data_o, 64'(c-1));
        chk("str_ctrl", {56'b0, out_ctrl_o}, 64'h01);
      end else begin
        chk("str_idle", {63'b0, out_valid_o}, 64'd0);
        chk("str_ictl", {56'b0, out_ctrl_o}, 64'd0);
      end
    end
    chk("str_cnt", {62'b0, count_o}, 64'd0);

    // backpressure and bubble collapse
    out_ready_i = 1'b0;
    drive(1'b1, 64'hA, 8'h01); step();
    chk("bp_cnt1", {62'b0, count_o}, 64'd1);
    drive(1'b0, 64'd0, 8'h00); step();
    chk("bp_cnt1b", {62'b0, count_o}, 64'd1);
    drive(1'b1, 64'hB, 8'h01); step();
    chk("bp_cnt2", {62'b0, count_o}, 64'd2);
    chk("bp_outA", out_data_o, 64'hA);
    drive(1'b0, 64'd0, 8'h00); step();
    chk("bp_cnt2b", {62'b0, count_o}, 64'd2);
    drive(1'b1, 64'hC, 8'h01); #1;
    chk("bp_rdyC", {63'b0, in_ready_o}, 64'd1);
    step();
    chk("bp_cnt3", {62'b0, count_o}, 64'd3);
    drive(1'b1, 64'hD, 8'h01); #1;
    chk("bp_full", {63'b0, in_ready_o}, 64'd0);
    step();
    chk("bp_cnt3b", {62'b0, count_o}, 64'd3);
    chk("bp_holdA", out_data_o, 64'hA);
    out_ready_i = 1'b1; #1;
    chk("bp_shift", {63'b0, in_ready_o}, 64'd1);
    step();
    chk("bp_outB", out_data_o, 64'hB);
    chk("bp_cnt3c", {62'b0, count_o}, 64'd3);
    drive(1'b0, 64'd0, 8'h00); step();
    chk("bp_outC", out_data_o, 64'hC);
    chk("bp_cnt2c", {62'b0, count_o}, 64'd2);
    step();
    chk("bp_outD", out_data_o, 64'hD);
    chk("bp_vD", {63'b0, out_valid_o}, 64'd1);
    step();
    chk("bp_empty", {63'b0, out_valid_o}, 64'd0);
    chk("bp_cnt0", {62'b0, count_o}, 64'd0);

    // stall mid-stream
    drive(1'b1, 64'h101, 8'h01); step();
    drive(1'b1, 64'h102, 8'h01); step();
    drive(1'b1, 64'h103, 8'h01); step();
    chk("st_pre", out_data_o, 64'h101);
    chk("st_cnt", {62'b0, count_o}, 64'd3);
    stall_i = 1'b1;
    drive(1'b1, 64'h104, 8'h01);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_rdy", {63'b0, in_ready_o}, 64'd0);
      step();
      chk("st_data", out_data_o, 64'h101);
      chk("st_valid", {63'b0, out_valid_o}, 64'd1);
      chk("st_hcnt", {62'b0, count_o}, 64'd3);
    end
    stall_i = 1'b0;
    step();
    chk("st_r1", out_data_o, 64'h102);
    drive(1'b1, 64'h105, 8'h01); step();
    chk("st_r2", out_data_o, 64'h103);
    drive(1'b0, 64'd0, 8'h00); step();
    chk("st_r3", out_data_o, 64'h104);
    step();
    chk("st_r4", out_data_o, 64'h105);
    step();
    chk("st_end", {63'b0, out_valid_o}, 64'd0);

    // flush a full chain
    out_ready_i = 1'b0;
    drive(1'b1, 64'h201, 8'h03); step();
    drive(1'b1, 64'h202, 8'h03); step();
    drive(1'b1, 64'h203, 8'h03); step();
    chk("fl_cnt3", {62'b0, count_o}, 64'd3);
    chk("fl_ctrl", {56'b0, out_ctrl_o}, 64'h03);
    flush_i = 1'b1;
    drive(1'b1, 64'h2FF, 8'h03); #1;
    chk("fl_rdy", {63'b0, in_ready_o}, 64'd0);
    step();
    flush_i = 1'b0;
    chk("fl_cnt0", {62'b0, count_o}, 64'd0);
    chk("fl_valid", {63'b0, out_valid_o}, 64'd0);
    chk("fl_ctrl0", {56'b0, out_ctrl_o}, 64'd0);
    drive(1'b0, 64'd0, 8'h00);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_drop", {63'b0, out_valid_o}, 64'd0);
    end

    // asynchronous reset mid-stream
    out_ready_i = 1'b0;
    drive(1'b1, 64'h301, 8'h01); step();
    drive(1'b1, 64'h302, 8'h01); step();
    drive(1'b0, 64'd0, 8'h00); step();
    chk("ar_cnt2", {62'b0, count_o}, 64'd2);
    chk("ar_out", out_data_o, 64'h301);
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar_valid", {63'b0, out_valid_o}, 64'd0);
    chk("ar_cnt", {62'b0, count_o}, 64'd0);
    chk("ar_data", out_data_o, 64'd0);
    chk("ar_ctrl", {56'b0, out_ctrl_o}, 64'd0);
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    step();
    step();
    chk("ar_after", {63'b0, out_valid_o}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
